// File: rtl/time_digit_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : time_digit_counter_if
// Brief    : Control/status bundle of one time-field counter.
// Revision : 1.0  initial release
// ============================================================================
interface time_digit_counter_if #(
  parameter int WIDTH = 7
);
  logic             tick;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             adj;
  logic [WIDTH-1:0] count;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             carry_out;
  logic             borrow_out;
  logic             at_limit;
  logic             load_err;

  modport master (
    output tick, dir, load, load_val, adj,
    input  count, tens, ones, carry_out, borrow_out, at_limit, load_err
  );

  modport slave (
    input  tick, dir, load, load_val, adj,
    output count, tens, ones, carry_out, borrow_out, at_limit, load_err
  );
endinterface
`default_nettype wire

// File: rtl/time_digit_counter.sv
`default_nettype none
// ============================================================================
// Module   : time_digit_counter
// Brief    : Modulo-N up/down time-field counter with load, adjust,
//            carry/borrow chaining and registered BCD digits.
// Revision : 1.0  initial release
// ============================================================================
module time_digit_counter #(
  parameter int MODULO      = 60,
  parameter int WIDTH       = 7,
  parameter int RESET_VALUE = 0
) (
  input  wire logic            clk_1Hz,
  input  wire logic            rst,
  time_digit_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_MAX        = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] c_RESET      = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH:0]   c_MOD_EXT    = (WIDTH + 1)'(MODULO);
  localparam logic [3:0]       c_RESET_TENS = 4'(RESET_VALUE / 10);
  localparam logic [3:0]       c_RESET_ONES = 4'(RESET_VALUE % 10);

  if (MODULO < 2 || MODULO > 100) begin : g_bad_modulo
    $error("time_digit_counter: MODULO out of range 2..100");
  end
  if ((2 ** WIDTH) < MODULO) begin : g_bad_width
    $error("time_digit_counter: WIDTH too small for MODULO");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULO) begin : g_bad_reset
    $error("time_digit_counter: RESET_VALUE must be below MODULO");
  end

  logic [WIDTH-1:0] r_count;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic             r_carry;
  logic             r_borrow;
  logic             r_load_err;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_load_ok;
  logic [WIDTH-1:0] w_step_up;
  logic [WIDTH-1:0] w_step_dn;
  logic [WIDTH-1:0] w_next_count;
  logic             w_carry;
  logic             w_borrow;
  logic             w_load_err;
  logic [31:0]      w_next_ext;
  logic [3:0]       w_next_tens;
  logic [3:0]       w_next_ones;

  assign w_at_max  = (r_count == c_MAX);
  assign w_at_zero = (r_count == '0);
  assign w_load_ok = ({1'b0, bus.load_val} < c_MOD_EXT);
  assign w_step_up = w_at_max  ? '0    : r_count + WIDTH'(1);
  assign w_step_dn = w_at_zero ? c_MAX : r_count - WIDTH'(1);

  // Only the highest-priority request acts; adjust wraps silently so that
  // setting one field never ripples into the field above.
  always_comb begin
    w_next_count = r_count;
    w_carry      = 1'b0;
    w_borrow     = 1'b0;
    w_load_err   = 1'b0;
    if (bus.load) begin
      if (w_load_ok) begin
        w_next_count = bus.load_val;
      end else begin
        w_load_err = 1'b1;
      end
    end else if (bus.adj) begin
      w_next_count = bus.dir ? w_step_up : w_step_dn;
    end else if (bus.tick) begin
      if (bus.dir) begin
        w_next_count = w_step_up;
        w_carry      = w_at_max;
      end else begin
        w_next_count = w_step_dn;
        w_borrow     = w_at_zero;
      end
    end
  end

  // Digits are derived from the next count so they line up with count.
  assign w_next_ext  = 32'(w_next_count);
  assign w_next_tens = 4'(w_next_ext / 32'd10);
  assign w_next_ones = 4'(w_next_ext % 32'd10);

  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      r_count    <= c_RESET;
      r_tens     <= c_RESET_TENS;
      r_ones     <= c_RESET_ONES;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_next_count;
      r_tens     <= w_next_tens;
      r_ones     <= w_next_ones;
      r_carry    <= w_carry;
      r_borrow   <= w_borrow;
      r_load_err <= w_load_err;
    end
  end

  assign bus.count      = r_count;
  assign bus.tens       = r_tens;
  assign bus.ones       = r_ones;
  assign bus.carry_out  = r_carry;
  assign bus.borrow_out = r_borrow;
  assign bus.load_err   = r_load_err;
  assign bus.at_limit   = bus.dir ? w_at_max : w_at_zero;

endmodule
`default_nettype wire

// File: tb/tb_time_digit_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_digit_counter
// Brief    : Seconds/hours/minutes counters against a modular-arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_time_digit_counter;

  logic clk_1Hz = 1'b0;
  logic rst;

  always #5 clk_1Hz = ~clk_1Hz;

  time_digit_counter_if #(.WIDTH(7)) if_a ();
  time_digit_counter_if #(.WIDTH(7)) if_b ();
  time_digit_counter_if #(.WIDTH(7)) if_c ();

  // Minutes field chained off the seconds field.
  assign if_c.tick = if_a.dir ? if_a.carry_out : if_a.borrow_out;
  assign if_c.dir  = if_a.dir;

  time_digit_counter #(.MODULO(60), .WIDTH(7), .RESET_VALUE(0)) u_sec (
    .clk_1Hz(clk_1Hz), .rst(rst), .bus(if_a.slave));
  time_digit_counter #(.MODULO(24), .WIDTH(7), .RESET_VALUE(7)) u_hrs (
    .clk_1Hz(clk_1Hz), .rst(rst), .bus(if_b.slave));
  time_digit_counter #(.MODULO(60), .WIDTH(7), .RESET_VALUE(0)) u_min (
    .clk_1Hz(clk_1Hz), .rst(rst), .bus(if_c.slave));

  int checks = 0;
  int errors = 0;

  int MODS[3] = '{60, 24, 60};
  int RVS[3]  = '{0, 7, 0};
  int m_cnt[3] = '{0, 7, 0};
  bit m_car[3];
  bit m_bor[3];
  bit m_lerr[3];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mstep(int i, bit r, bit ld, int lv, bit ad, bit tk, bit d);
    m_car[i]  = 1'b0;
    m_bor[i]  = 1'b0;
    m_lerr[i] = 1'b0;
    if (r) begin
      m_cnt[i] = RVS[i];
    end else if (ld) begin
      if (lv < MODS[i]) m_cnt[i] = lv;
      else              m_lerr[i] = 1'b1;
    end else if (ad) begin
      m_cnt[i] = d ? (m_cnt[i] + 1) % MODS[i] : (m_cnt[i] + MODS[i] - 1) % MODS[i];
    end else if (tk) begin
      if (d) begin
        m_car[i] = (m_cnt[i] == MODS[i] - 1);
        m_cnt[i] = (m_cnt[i] + 1) % MODS[i];
      end else begin
        m_bor[i] = (m_cnt[i] == 0);
        m_cnt[i] = (m_cnt[i] + MODS[i] - 1) % MODS[i];
      end
    end
  endfunction

  task automatic chk_inst(string nm, int i, int cnt, int tn, int on,
                          int c, int b, int le, int al, int d);
    int exp_al;
    exp_al = d ? int'(m_cnt[i] == MODS[i] - 1) : int'(m_cnt[i] == 0);
    chk({nm, ".count"},    cnt, m_cnt[i]);
    chk({nm, ".tens"},     tn,  m_cnt[i] / 10);
    chk({nm, ".ones"},     on,  m_cnt[i] % 10);
    chk({nm, ".carry"},    c,   int'(m_car[i]));
    chk({nm, ".borrow"},   b,   int'(m_bor[i]));
    chk({nm, ".load_err"}, le,  int'(m_lerr[i]));
    chk({nm, ".at_limit"}, al,  exp_al);
  endtask

  task automatic compare_all();
    chk_inst("sec", 0, int'(if_a.count), int'(if_a.tens), int'(if_a.ones),
             int'(if_a.carry_out), int'(if_a.borrow_out), int'(if_a.load_err),
             int'(if_a.at_limit), int'(if_a.dir));
    chk_inst("hrs", 1, int'(if_b.count), int'(if_b.tens), int'(if_b.ones),
             int'(if_b.carry_out), int'(if_b.borrow_out), int'(if_b.load_err),
             int'(if_b.at_limit), int'(if_b.dir));
    chk_inst("min", 2, int'(if_c.count), int'(if_c.tens), int'(if_c.ones),
             int'(if_c.carry_out), int'(if_c.borrow_out), int'(if_c.load_err),
             int'(if_c.at_limit), int'(if_c.dir));
  endtask

  // One clock: snapshot stimulus, step the model after the edge, compare.
  task automatic cycle();
    bit r;
    bit ctick;
    bit ld[3];
    bit ad[3];
    bit tk[3];
    bit dd[3];
    int lv[3];
    r     = rst;
    ctick = if_a.dir ? m_car[0] : m_bor[0];
    ld[0] = if_a.load; lv[0] = int'(if_a.load_val); ad[0] = if_a.adj; tk[0] = if_a.tick; dd[0] = if_a.dir;
    ld[1] = if_b.load; lv[1] = int'(if_b.load_val); ad[1] = if_b.adj; tk[1] = if_b.tick; dd[1] = if_b.dir;
    ld[2] = if_c.load; lv[2] = int'(if_c.load_val); ad[2] = if_c.adj; tk[2] = ctick;     dd[2] = if_a.dir;
    @(posedge clk_1Hz);
    #1;
    for (int i = 0; i < 3; i++) mstep(i, r, ld[i], lv[i], ad[i], tk[i], dd[i]);
    compare_all();
  endtask

  task automatic clear_inputs();
    if_a.tick = 1'b0; if_a.dir = 1'b1; if_a.load = 1'b0; if_a.load_val = '0; if_a.adj = 1'b0;
    if_b.tick = 1'b0; if_b.dir = 1'b1; if_b.load = 1'b0; if_b.load_val = '0; if_b.adj = 1'b0;
    if_c.load = 1'b0; if_c.load_val = '0; if_c.adj = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    cycle();
    cycle();
    rst = 1'b0;
    chk("lit_reset_sec_count", int'(if_a.count), 0);
    chk("lit_reset_sec_tens", int'(if_a.tens), 0);
    chk("lit_reset_sec_ones", int'(if_a.ones), 0);
    chk("lit_reset_hrs_ones", int'(if_b.ones), 7);

    // Up wrap on seconds, with minutes following one edge later.
    if_a.tick = 1'b1;
    repeat (59) cycle();
    chk("lit_up_count59", int'(if_a.count), 59);
    chk("lit_up_tens5", int'(if_a.tens), 5);
    chk("lit_up_ones9", int'(if_a.ones), 9);
    chk("lit_up_at_limit", int'(if_a.at_limit), 1);
    cycle();
    chk("lit_wrap_count0", int'(if_a.count), 0);
    chk("lit_wrap_carry1", int'(if_a.carry_out), 1);
    chk("lit_wrap_min_still0", int'(if_c.count), 0);
    cycle();
    chk("lit_after_wrap_count1", int'(if_a.count), 1);
    chk("lit_after_wrap_carry0", int'(if_a.carry_out), 0);
    chk("lit_cascade_min1", int'(if_c.count), 1);
    if_a.tick = 1'b0;

    // Down wrap on hours.
    if_b.load = 1'b1; if_b.load_val = 7'd0;
    cycle();
    if_b.load = 1'b0; if_b.dir = 1'b0; if_b.tick = 1'b1;
    cycle();
    chk("lit_down_count23", int'(if_b.count), 23);
    chk("lit_down_tens2", int'(if_b.tens), 2);
    chk("lit_down_ones3", int'(if_b.ones), 3);
    chk("lit_down_borrow", int'(if_b.borrow_out), 1);
    if_b.tick = 1'b0;
    cycle();
    chk("lit_down_borrow_gone", int'(if_b.borrow_out), 0);

    // Load range check.
    if_b.load = 1'b1; if_b.load_val = 7'd23;
    cycle();
    chk("lit_load23", int'(if_b.count), 23);
    if_b.load_val = 7'd24;
    cycle();
    chk("lit_load24_hold", int'(if_b.count), 23);
    chk("lit_load24_err", int'(if_b.load_err), 1);
    if_b.load_val = 7'd127;
    cycle();
    chk("lit_load127_hold", int'(if_b.count), 23);
    chk("lit_load127_err", int'(if_b.load_err), 1);
    if_b.load = 1'b0;
    cycle();
    chk("lit_load_err_gone", int'(if_b.load_err), 0);

    // Adjust beats tick; load beats adjust; reset beats load.
    if_a.load = 1'b1; if_a.load_val = 7'd59;
    cycle();
    if_a.load = 1'b0; if_a.adj = 1'b1; if_a.tick = 1'b1; if_a.dir = 1'b1;
    cycle();
    chk("lit_adj_wrap0", int'(if_a.count), 0);
    chk("lit_adj_no_carry", int'(if_a.carry_out), 0);
    if_a.load = 1'b1; if_a.load_val = 7'd30;
    cycle();
    chk("lit_load_over_adj", int'(if_a.count), 30);
    rst = 1'b1;
    cycle();
    chk("lit_rst_over_load", int'(if_a.count), 0);
    chk("lit_rst_hrs", int'(if_b.count), 7);
    rst = 1'b0;
    clear_inputs();
    cycle();

    // Randomized traffic.
    repeat (3000) begin
      rst           = ($urandom_range(0, 63) == 0);
      if_a.tick     = ($urandom_range(0, 3) != 0);
      if_a.load     = ($urandom_range(0, 15) == 0);
      if_a.load_val = 7'($urandom_range(0, 127));
      if_a.adj      = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) if_a.dir = ~if_a.dir;
      if_b.tick     = ($urandom_range(0, 1) != 0);
      if_b.load     = ($urandom_range(0, 9) == 0);
      if_b.load_val = 7'($urandom_range(0, 127));
      if_b.adj      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) if_b.dir = ~if_b.dir;
      if_c.load     = ($urandom_range(0, 31) == 0);
      if_c.load_val = 7'($urandom_range(0, 127));
      if_c.adj      = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
